// File: rtl/traffic_pkg.sv
// Shared Traffic definitions: parameter defaults, wait saturation value, direction enum
// and the direction-to-green-lamp selector used by the detector channels.
package traffic_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd4;
    localparam int unsigned DB_W_DEF            = 32'd3;
    localparam int unsigned WAIT_W_DEF          = 32'd8;
    localparam int unsigned STUCK_CYCLES_DEF    = 32'd256;

    localparam logic [WAIT_W_DEF-1:0] WAIT_MAX = {WAIT_W_DEF{1'b1}};

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_e;

    // An unknown direction reports "served" so its request can never stick high.
    function automatic logic served(input dir_e dir, input logic ns_green, input logic ew_green);
        logic green;
        case (dir)
            DIR_NS:  green = ns_green;
            DIR_EW:  green = ew_green;
            default: green = 1'b1;
        endcase
        return green;
    endfunction

endpackage

// File: rtl/det_channel.sv
// One loop-sensor channel: 2-flop sync, debounce, served-clears request latch and
// saturating wait counter. Optional stuck-high detection under STUCK_SENSOR_EN.
module det_channel
    import traffic_pkg::*;
#(
    parameter dir_e        DIR             = DIR_NS,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned DB_W            = DB_W_DEF,
    parameter int unsigned WAIT_W          = WAIT_W_DEF,
    parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sensor_raw,
    input  logic              ns_green,
    input  logic              ew_green,
    output logic              detect,
    output logic [WAIT_W-1:0] wait_count,
    output logic              stuck
);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = {WAIT_W{1'b1}};

    if (((32'd1 << DB_W) <= DEBOUNCE_CYCLES) || (DEBOUNCE_CYCLES < 32'd1) || (STUCK_CYCLES < 32'd1)) begin : g_bad_cfg
        $error("det_channel: invalid DEBOUNCE_CYCLES/DB_W/STUCK_CYCLES combination");
    end

    logic [1:0]        sync_r;
    logic              filt_r;
    logic              filt_next_s;
    logic [DB_W-1:0]   db_cnt_r;
    logic [DB_W-1:0]   db_cnt_next_s;
    logic              req_r;
    logic              req_next_s;
    logic [WAIT_W-1:0] wait_r;
    logic [WAIT_W-1:0] wait_next_s;
    logic              green_s;
    logic              stuck_active_s;
    logic              toggle_s;

    assign green_s = served(DIR, ns_green, ew_green);

    // Two-flop synchroniser; sync_r[1] is the only consumer-visible copy of the sensor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], sensor_raw};
        end
    end

    // Debounce, request latch and wait counter next-state.
    always_comb begin
        filt_next_s   = filt_r;
        db_cnt_next_s = {DB_W{1'b0}};
        req_next_s    = req_r;
        wait_next_s   = {WAIT_W{1'b0}};

        if (sync_r[1] != filt_r) begin
            if (db_cnt_r == DB_LAST) begin
                filt_next_s   = sync_r[1];
                db_cnt_next_s = {DB_W{1'b0}};
            end else begin
                db_cnt_next_s = db_cnt_r + DB_W'(32'd1);
            end
        end else begin
            db_cnt_next_s = {DB_W{1'b0}};
        end

        // Service always wins over a simultaneous set.
        if (green_s) begin
            req_next_s = 1'b0;
        end else if (stuck_active_s) begin
            req_next_s = toggle_s;
        end else if (filt_r) begin
            req_next_s = 1'b1;
        end else begin
            req_next_s = req_r;
        end

        if (req_r && req_next_s) begin
            if (wait_r == WAIT_SAT) begin
                wait_next_s = WAIT_SAT;
            end else begin
                wait_next_s = wait_r + WAIT_W'(32'd1);
            end
        end else begin
            wait_next_s = {WAIT_W{1'b0}};
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r   <= 1'b0;
            db_cnt_r <= {DB_W{1'b0}};
            req_r    <= 1'b0;
            wait_r   <= {WAIT_W{1'b0}};
        end else begin
            filt_r   <= filt_next_s;
            db_cnt_r <= db_cnt_next_s;
            req_r    <= req_next_s;
            wait_r   <= wait_next_s;
        end
    end

    assign detect     = req_r;
    assign wait_count = wait_r;

`ifdef STUCK_SENSOR_EN
    localparam int unsigned      SC_W     = $clog2(STUCK_CYCLES + 32'd1);
    localparam logic [SC_W-1:0]  SC_LIMIT = SC_W'(STUCK_CYCLES);

    logic [SC_W-1:0] stuck_cnt_r;
    logic [SC_W-1:0] stuck_cnt_next_s;
    logic            stuck_r;
    logic            stuck_next_s;
    logic            toggle_r;

    // Count filtered-high cycles; the flag is sticky until reset.
    always_comb begin
        stuck_cnt_next_s = {SC_W{1'b0}};
        stuck_next_s     = stuck_r;
        if (!filt_r) begin
            stuck_cnt_next_s = {SC_W{1'b0}};
        end else if (stuck_cnt_r == SC_LIMIT) begin
            stuck_cnt_next_s = stuck_cnt_r;
        end else begin
            stuck_cnt_next_s = stuck_cnt_r + SC_W'(32'd1);
        end
        if (stuck_cnt_r == SC_LIMIT) begin
            stuck_next_s = 1'b1;
        end else begin
            stuck_next_s = stuck_r;
        end
    end

    // Stuck counter, flag and the free-running fail-safe toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_cnt_r <= {SC_W{1'b0}};
            stuck_r     <= 1'b0;
            toggle_r    <= 1'b0;
        end else begin
            stuck_cnt_r <= stuck_cnt_next_s;
            stuck_r     <= stuck_next_s;
            toggle_r    <= ~toggle_r;
        end
    end

    assign stuck_active_s = stuck_r;
    assign toggle_s       = toggle_r;
    assign stuck          = stuck_r;
`else
    assign stuck_active_s = 1'b0;
    assign toggle_s       = 1'b0;
    assign stuck          = 1'b0;
`endif

endmodule

// File: rtl/vehicle_detect_conditioner.sv
// Conditions NS/EW loop sensors into latched vehicle-detect requests for Traffic.
// Define STUCK_SENSOR_EN to build the stuck-sensor detection and fail-safe request.
module vehicle_detect_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned DB_W            = DB_W_DEF,
    parameter int unsigned WAIT_W          = WAIT_W_DEF,
    parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ns_sensor_raw,
    input  logic              ew_sensor_raw,
    input  logic              NS_GREEN,
    input  logic              EW_GREEN,
    output logic              NS_VEHICLE_DETECT,
    output logic              EW_VEHICLE_DETECT,
    output logic [WAIT_W-1:0] ns_wait_count,
    output logic [WAIT_W-1:0] ew_wait_count,
    output logic              ns_stuck,
    output logic              ew_stuck
);

    det_channel #(
        .DIR             (DIR_NS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W),
        .WAIT_W          (WAIT_W),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ns (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_raw (ns_sensor_raw),
        .ns_green   (NS_GREEN),
        .ew_green   (EW_GREEN),
        .detect     (NS_VEHICLE_DETECT),
        .wait_count (ns_wait_count),
        .stuck      (ns_stuck)
    );

    det_channel #(
        .DIR             (DIR_EW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W),
        .WAIT_W          (WAIT_W),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ew (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_raw (ew_sensor_raw),
        .ns_green   (NS_GREEN),
        .ew_green   (EW_GREEN),
        .detect     (EW_VEHICLE_DETECT),
        .wait_count (ew_wait_count),
        .stuck      (ew_stuck)
    );

endmodule

// File: tb/tb_vehicle_detect_conditioner.sv
// Self-checking bench for vehicle_detect_conditioner: directed vector table, corner
// sequences, and randomized traffic against a window-based reference model.
module tb_vehicle_detect_conditioner;

    localparam int DB      = 4;
    localparam int SAT     = 255;
    localparam int NVEC    = 20;
`ifdef STUCK_SENSOR_EN
    localparam logic STUCK_EXP = 1'b1;
`else
    localparam logic STUCK_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ns_raw = 1'b0;
    logic       ew_raw = 1'b0;
    logic       ns_g = 1'b0;
    logic       ew_g = 1'b0;
    logic       ns_det, ew_det, ns_stuck, ew_stuck;
    logic [7:0] ns_wait, ew_wait;

    int checks = 0;
    int errors = 0;
    bit chk_model = 1'b0;

    vehicle_detect_conditioner dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ns_sensor_raw     (ns_raw),
        .ew_sensor_raw     (ew_raw),
        .NS_GREEN          (ns_g),
        .EW_GREEN          (ew_g),
        .NS_VEHICLE_DETECT (ns_det),
        .EW_VEHICLE_DETECT (ew_det),
        .ns_wait_count     (ns_wait),
        .ew_wait_count     (ew_wait),
        .ns_stuck          (ns_stuck),
        .ew_stuck          (ew_stuck)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: synced value = raw sampled two edges earlier; the filtered level
    // moves to v once the last DB synced samples all equal v.
    bit raw_q[2][$];
    bit syn_q[2][$];
    int m_filt[2];
    int m_req[2];
    int m_wait[2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            raw_q[d].delete();
            syn_q[d].delete();
            raw_q[d].push_back(1'b0);
            raw_q[d].push_back(1'b0);
            m_filt[d] = 0;
            m_req[d]  = 0;
            m_wait[d] = 0;
        end
    endfunction

    function automatic void model_edge();
        bit r[2];
        bit g[2];
        r[0] = ns_raw; r[1] = ew_raw;
        g[0] = ns_g;   g[1] = ew_g;
        for (int d = 0; d < 2; d++) begin
            bit s;
            bit all_same;
            int nf, nr, nw;
            raw_q[d].push_back(r[d]);
            s = raw_q[d][raw_q[d].size() - 3];
            syn_q[d].push_back(s);
            if (raw_q[d].size() > 8) void'(raw_q[d].pop_front());
            if (syn_q[d].size() > 8) void'(syn_q[d].pop_front());
            nf = m_filt[d];
            if (syn_q[d].size() >= DB) begin
                all_same = 1'b1;
                for (int i = 1; i <= DB; i++)
                    if (syn_q[d][syn_q[d].size() - i] != s) all_same = 1'b0;
                if (all_same && (int'(s) != m_filt[d])) nf = s;
            end
            nr = g[d] ? 0 : (m_filt[d] != 0 ? 1 : m_req[d]);
            nw = (m_req[d] != 0 && nr != 0) ? ((m_wait[d] + 1 > SAT) ? SAT : m_wait[d] + 1) : 0;
            m_filt[d] = nf;
            m_req[d]  = nr;
            m_wait[d] = nw;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        if (chk_model) begin
            check("rand_ns_det",  ns_det,  m_req[0]);
            check("rand_ew_det",  ew_det,  m_req[1]);
            check("rand_ns_wait", ns_wait, m_wait[0]);
            check("rand_ew_wait", ew_wait, m_wait[1]);
        end
    endtask

    typedef struct {
        logic       raw;
        logic       green;
        logic       det;
        logic [7:0] wt;
    } vec_t;

    vec_t tv[NVEC];

    initial begin
        logic [7:0] prev;

        // NS clean rise, service, green release, sensor drop.
        for (int i = 0; i < 6; i++) tv[i] = '{1'b1, 1'b0, 1'b0, 8'd0};
        tv[6]  = '{1'b1, 1'b0, 1'b1, 8'd0};
        tv[7]  = '{1'b1, 1'b0, 1'b1, 8'd1};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 8'd2};
        tv[9]  = '{1'b1, 1'b1, 1'b0, 8'd0};
        tv[10] = '{1'b1, 1'b0, 1'b1, 8'd0};
        tv[11] = '{1'b1, 1'b0, 1'b1, 8'd1};
        for (int i = 12; i < 18; i++) tv[i] = '{1'b0, 1'b1, 1'b0, 8'd0};
        tv[18] = '{1'b0, 1'b0, 1'b0, 8'd0};
        tv[19] = '{1'b0, 1'b0, 1'b0, 8'd0};

        model_reset();
        #3;
        check("reset_ns_det",  ns_det,  0);
        check("reset_ew_det",  ew_det,  0);
        check("reset_ns_wait", ns_wait, 0);
        check("reset_ew_wait", ew_wait, 0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            ns_raw = tv[i].raw;
            ns_g   = tv[i].green;
            tick();
            check($sformatf("vec%0d_ns_det", i),  ns_det,  tv[i].det);
            check($sformatf("vec%0d_ns_wait", i), ns_wait, tv[i].wt);
            check($sformatf("vec%0d_ew_det", i),  ew_det,  0);
        end

        // EW bounce shorter than the debounce window.
        ew_raw = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) ew_raw = 1'b0;
            tick();
            check("bounce_ew_det",  ew_det,  0);
            check("bounce_ew_wait", ew_wait, 0);
        end

        // Asynchronous reset mid-cycle with a request pending.
        ns_raw = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("pre_reset_ns_det", ns_det, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ns_det",   ns_det,   0);
        check("async_rst_ns_wait",  ns_wait,  0);
        check("async_rst_ew_det",   ew_det,   0);
        check("async_rst_ew_wait",  ew_wait,  0);
        check("async_rst_ns_stuck", ns_stuck, 0);
        check("async_rst_ew_stuck", ew_stuck, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("post_rst_rise%0d", i), ns_det, (i == 6) ? 1 : 0);
        end
        ns_raw = 1'b0;
        ns_g   = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        ns_g = 1'b0;
        tick();
        check("ns_idle", ns_det, 0);

        // EW wait-count saturation with the request latched and unserved.
        ew_raw = 1'b1;
        prev   = 8'd0;
        for (int i = 0; i < 312; i++) begin
            if (i == 12) ew_raw = 1'b0;
            tick();
            check("sat_no_wrap", (ew_wait >= prev) ? 1 : 0, 1);
            prev = ew_wait;
        end
        check("sat_value", ew_wait, SAT);
        check("sat_det",   ew_det,  1);
        tick();
        check("sat_hold", ew_wait, SAT);
        ew_g = 1'b1;
        tick();
        check("sat_served_det",  ew_det,  0);
        check("sat_served_wait", ew_wait, 0);
        ew_g = 1'b0;

        // NS sensor stuck high, then released.
        ns_g   = 1'b1;
        ns_raw = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        check("stuck_set", ns_stuck, STUCK_EXP);
        ns_raw = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("stuck_sticky", ns_stuck, STUCK_EXP);
        check("ew_stuck_clear", ew_stuck, 0);
        ns_g = 1'b0;

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ns_raw = 1'b0;
        ew_raw = 1'b0;
        chk_model = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(4, 0) == 0) ns_raw = ~ns_raw;
            if ($urandom_range(4, 0) == 0) ew_raw = ~ew_raw;
            ns_g = ($urandom_range(7, 0) == 0);
            ew_g = ($urandom_range(7, 0) == 0);
            tick();
        end
        chk_model = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
